// File: rtl/axi_node_pkg.sv
// Shared axi_node definitions: default master-index type and the round-robin
// pointer wrap used by the AW arbiters of the node.
package axi_node_pkg;

  localparam int AXI_N_MASTER   = 5;
  localparam int AXI_LOG_MASTER = $clog2(AXI_N_MASTER);

  typedef logic [AXI_LOG_MASTER-1:0] master_idx_t;

  // Next round-robin start position after granting idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_wr_order_fifo.sv
// In-order record of granted AW masters; the head selects whose W burst is
// forwarded. Extra pointer MSB separates full from empty.
module axi_wr_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign head  = mem[rd_ptr_reg[PTR_W-1:0]];

  // Storage needs no reset: the head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/axi_aw_w_sequencer.sv
// AW round-robin arbiter with lock override and stable-hold, plus W steering
// that follows AW grant order one burst at a time.
module axi_aw_w_sequencer
  import axi_node_pkg::*;
#(
  parameter int N_MASTER   = AXI_N_MASTER,
  parameter int LOG_MASTER = $clog2(N_MASTER),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_MASTER-1:0]   aw_req_i,
  output logic [N_MASTER-1:0]   aw_gnt_o,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [LOG_MASTER-1:0] aw_sel_o,
  input  logic                  lock_i,
  input  logic [LOG_MASTER-1:0] lock_sel_i,
  input  logic [N_MASTER-1:0]   w_valid_i,
  input  logic [N_MASTER-1:0]   w_last_i,
  output logic [N_MASTER-1:0]   w_ready_o,
  output logic                  w_valid_o,
  output logic                  w_last_o,
  input  logic                  w_ready_i,
  output logic [LOG_MASTER-1:0] w_sel_o,
  output logic                  busy_o
);

  logic [LOG_MASTER-1:0] rr_ptr_reg;
  logic                  hold_reg;
  logic [LOG_MASTER-1:0] hold_idx_reg;

  logic [N_MASTER-1:0]   eligible;
  logic [LOG_MASTER-1:0] win_idx;
  logic                  win_found;
  logic [LOG_MASTER-1:0] sel;
  logic                  aw_hs;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LOG_MASTER-1:0] head;
  logic                  w_pop;

  // rst_n gates eligibility so nothing is offered while the node is in reset.
  for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_elig
    assign eligible[gi] = rst_n & aw_req_i[gi] & ~fifo_full &
                          (~lock_i | (lock_sel_i == LOG_MASTER'(gi)));
  end

  always_comb begin
    logic [LOG_MASTER:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      cand = {1'b0, rr_ptr_reg} + (LOG_MASTER+1)'(k);
      if (cand >= (LOG_MASTER+1)'(N_MASTER)) cand = cand - (LOG_MASTER+1)'(N_MASTER);
      if (!win_found && eligible[cand[LOG_MASTER-1:0]]) begin
        win_idx   = cand[LOG_MASTER-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign sel        = hold_reg ? hold_idx_reg : win_idx;
  assign aw_valid_o = hold_reg ? aw_req_i[hold_idx_reg] : win_found;
  assign aw_sel_o   = aw_valid_o ? sel : '0;
  assign aw_hs      = aw_valid_o & aw_ready_i;

  for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_aw_gnt
    assign aw_gnt_o[gi] = aw_hs & (sel == LOG_MASTER'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= '0;
      hold_reg     <= 1'b0;
      hold_idx_reg <= '0;
    end else if (aw_hs) begin
      rr_ptr_reg <= LOG_MASTER'(rr_next(32'(sel), N_MASTER));
      hold_reg   <= 1'b0;
    end else if (aw_valid_o) begin
      hold_reg     <= 1'b1;
      hold_idx_reg <= sel;
    end
  end

  axi_wr_order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LOG_MASTER)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (aw_hs),
    .push_data (sel),
    .pop       (w_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head only becomes visible the cycle after its push, so W never bypasses AW.
  assign w_sel_o   = fifo_empty ? '0 : head;
  assign w_valid_o = ~fifo_empty & w_valid_i[head];
  assign w_last_o  = ~fifo_empty & w_last_i[head];
  assign w_pop     = w_valid_o & w_ready_i & w_last_o;
  assign busy_o    = ~fifo_empty;

  for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_w_ready
    assign w_ready_o[gi] = ~fifo_empty & w_ready_i & (head == LOG_MASTER'(gi));
  end

  a_hold_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(hold_reg && fifo_full));
  a_hold_req_kept: assert property (@(posedge clk) disable iff (!rst_n) hold_reg |-> aw_req_i[hold_idx_reg]);
  a_aw_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(aw_gnt_o));
  a_w_rdy_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_ready_o));

endmodule

// File: doc/axi_aw_w_sequencer.md
Name: axi_aw_w_sequencer

Overview:
- Write-path controller for the AXI node slave port: round-robin arbitrates the AW channel among N_MASTER requesters.
- Records each accepted AW grant in an in-order FIFO and steers the W channel to the master at the FIFO head until that burst's WLAST.
- Sits beside the request arbitration tree. Drives mux selects for the AW and W payload paths and returns per-master ready/grant.
- Supports an exclusive-lock override that restricts AW eligibility to one master.

Parameters:
N_MASTER, 5, number of requesting masters (>=2)
LOG_MASTER, $clog2(N_MASTER), width of master index
FIFO_DEPTH, 4, outstanding AW grants whose W bursts are not yet complete (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
aw_req_i  in  N_MASTER  per-master AW valid
aw_gnt_o  out  N_MASTER  per-master AW ready (one-hot or zero)
aw_valid_o  out  1  AW valid toward slave
aw_ready_i  in  1  AW ready from slave
aw_sel_o  out  LOG_MASTER  index of master driving AW payload mux
lock_i  in  1  exclusive lock active
lock_sel_i  in  LOG_MASTER  only master eligible while lock_i=1
w_valid_i  in  N_MASTER  per-master W valid
w_last_i  in  N_MASTER  per-master W last
w_ready_o  out  N_MASTER  per-master W ready
w_valid_o  out  1  W valid toward slave
w_last_o  out  1  W last toward slave
w_ready_i  in  1  W ready from slave
w_sel_o  out  LOG_MASTER  index of master driving W payload mux (FIFO head)
busy_o  out  1  FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, hold flag=0, FIFO empty. All outputs 0. Reset mid-burst discards outstanding entries; upstream is reset with the node.
- Eligibility: eligible[i] = aw_req_i[i] & !full & (!lock_i | lock_sel_i==i). lock_sel_i >= N_MASTER yields no eligible master.
- Winner: first eligible index searching rr_ptr, rr_ptr+1, ... wrapping N_MASTER-1 -> 0. Combinational, zero-cycle.
- Hold: when aw_valid_o=1 and aw_ready_i=0, register the winner in hold_idx and set hold=1. While hold=1, aw_sel_o=hold_idx and aw_valid_o=aw_req_i[hold_idx], regardless of lock_i or other requests (AXI payload stability). hold clears on handshake.
- aw_valid_o = hold ? aw_req_i[hold_idx] : |eligible. aw_sel_o = selected index when aw_valid_o, else 0.
- aw_gnt_o[sel] = aw_valid_o & aw_ready_i; all other bits 0.
- AW handshake (aw_valid_o & aw_ready_i):
  - push sel into FIFO;
  - rr_ptr <= (sel==N_MASTER-1) ? 0 : sel+1.
  - rr_ptr does not change otherwise.
- Full FIFO: no new AW arbitration; aw_valid_o=0 unless hold=1. Hold can only be set when not full, and full only arises from a handshake that clears hold, so hold=1 with full=1 is unreachable; assert this.
- W steering: head=FIFO[rd_ptr].
  - w_sel_o = head when !empty, else 0.
  - w_valid_o = !empty & w_valid_i[head]; w_last_o = !empty & w_last_i[head].
  - w_ready_o[head] = !empty & w_ready_i; all other bits 0.
- Pop on w_valid_o & w_ready_i & w_last_o.
- No bypass: W for an AW accepted in cycle t is steered from cycle t+1 at earliest. W beats arriving earlier stall (ready=0).
- Simultaneous push and pop: count unchanged, both pointers advance. Push when full is impossible (gated). Pop when empty is impossible.
- Pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.
- busy_o = !empty.
- Assertions:
  - aw_req_i[hold_idx] drop while hold=1 is a protocol violation; flagged.
  - aw_gnt_o and w_ready_o are always at most one-hot.

Decomposition:
- Shared axi_node package: master-index type (LOG_MASTER bits) and the round-robin next-pointer wrap function, shared with axi_RR_Flag_Req users.
- One sub-module: axi_wr_order_fifo (FIFO_DEPTH x LOG_MASTER, push/pop, full/empty, async active-low reset).
- Arbitration, hold and W steering stay in the top.

Test Plan:
- All masters request AW with aw_ready_i=1 for 5 cycles, FIFO drained each cycle -> grants to masters 0,1,2,3,4 in order; rr_ptr returns to 0.
- Master 2 requests, aw_ready_i=0 for 3 cycles, master 1 then raises its request -> aw_sel_o stays 2 and aw_valid_o=1 throughout; grant to 2 on ready; master 1 is granted next.
- lock_i=1, lock_sel_i=3, requests from 0 and 3 -> only master 3 is granted. lock_sel_i=6 with N_MASTER=5 -> aw_valid_o=0.
- 4 AW accepted (masters 1,0,4,2) with W held off -> FIFO full, aw_valid_o=0 despite requests. Then W bursts of length 2, 1, 3, 1 drain in order 1,0,4,2. aw_valid_o re-asserts the cycle after the first pop.
- AW from master 0 accepted in cycle t, master 0 w_valid_i already high -> w_ready_o[0]=0 in t, 1 in t+1. Single-beat last pops in t+1 while a new AW pushes in t+1 -> count unchanged.
- rst_n deasserted asynchronously mid-burst with 3 entries queued -> all outputs 0 immediately, busy_o=0. After release, first grant goes to the lowest requesting index.
